// File: rtl/aclk_time_counter_if.sv
// Bundle of the tick/load inputs and time/status outputs of the
// alarm-clock time-of-day counter. The counter uses the slave view,
// whoever feeds it (time generator, keypad path, bench) uses the master view.
`timescale 1ns/1ps
`default_nettype none

interface aclk_time_counter_if;
    logic       one_minute;
    logic       load_new_c;
    logic [3:0] new_current_time_ms_hr;
    logic [3:0] new_current_time_ls_hr;
    logic [3:0] new_current_time_ms_min;
    logic [3:0] new_current_time_ls_min;
    logic [3:0] current_time_ms_hr;
    logic [3:0] current_time_ls_hr;
    logic [3:0] current_time_ms_min;
    logic [3:0] current_time_ls_min;
    logic       day_tick;
    logic       load_error;

    modport master (
        output one_minute,
        output load_new_c,
        output new_current_time_ms_hr,
        output new_current_time_ls_hr,
        output new_current_time_ms_min,
        output new_current_time_ls_min,
        input  current_time_ms_hr,
        input  current_time_ls_hr,
        input  current_time_ms_min,
        input  current_time_ls_min,
        input  day_tick,
        input  load_error
    );

    modport slave (
        input  one_minute,
        input  load_new_c,
        input  new_current_time_ms_hr,
        input  new_current_time_ls_hr,
        input  new_current_time_ms_min,
        input  new_current_time_ls_min,
        output current_time_ms_hr,
        output current_time_ls_hr,
        output current_time_ms_min,
        output current_time_ls_min,
        output day_tick,
        output load_error
    );
endinterface

`default_nettype wire

// File: rtl/aclk_time_counter.sv
// Alarm-clock time-of-day counter: holds HH:MM as four BCD digits, advances
// one minute per tick, accepts range-checked loads (load beats tick), and
// pulses day_tick for the cycle the time rolls over to 00:00.
// HOURS_PER_DAY is meant to be 24 or 12; any other value behaves as 24.
`timescale 1ns/1ps
`default_nettype none

module aclk_time_counter #(
    parameter int HOURS_PER_DAY = 24
) (
    input  wire logic          clk,
    input  wire logic          reset,
    aclk_time_counter_if.slave bus
);

    localparam bool_12h = (HOURS_PER_DAY == 12);
    localparam logic [3:0] MAX_MS_HR  = bool_12h ? 4'd1 : 4'd2;
    localparam logic [3:0] MAX_LS_HR  = bool_12h ? 4'd1 : 4'd3;
    localparam logic [7:0] HOUR_LIMIT = bool_12h ? 8'd12 : 8'd24;

    // Range check of a candidate load: legal BCD digits and hours below the wrap point.
    function automatic logic load_is_valid(
        input logic [3:0] ms_hr,
        input logic [3:0] ls_hr,
        input logic [3:0] ms_min,
        input logic [3:0] ls_min
    );
        logic [7:0] hours;
        hours = ({4'd0, ms_hr} * 8'd10) + {4'd0, ls_hr};
        return (ls_min <= 4'd9) && (ms_min <= 4'd5) && (ls_hr <= 4'd9) &&
               (hours < HOUR_LIMIT);
    endfunction

    logic [3:0] ms_hr_q,  ms_hr_d;
    logic [3:0] ls_hr_q,  ls_hr_d;
    logic [3:0] ms_min_q, ms_min_d;
    logic [3:0] ls_min_q, ls_min_d;
    logic       day_tick_q, day_tick_d;
    logic       load_error_q, load_error_d;
    logic       load_ok_s;
    logic       at_last_hour_s;

    assign load_ok_s = load_is_valid(bus.new_current_time_ms_hr,
                                     bus.new_current_time_ls_hr,
                                     bus.new_current_time_ms_min,
                                     bus.new_current_time_ls_min);

    assign at_last_hour_s = (ms_hr_q == MAX_MS_HR) && (ls_hr_q == MAX_LS_HR);

    // Next-state: load has priority and swallows any same-cycle tick; otherwise the tick ripples the BCD chain.
    always_comb begin
        ms_hr_d      = ms_hr_q;
        ls_hr_d      = ls_hr_q;
        ms_min_d     = ms_min_q;
        ls_min_d     = ls_min_q;
        day_tick_d   = 1'b0;
        load_error_d = load_error_q;
        if (bus.load_new_c) begin
            if (load_ok_s) begin
                ms_hr_d      = bus.new_current_time_ms_hr;
                ls_hr_d      = bus.new_current_time_ls_hr;
                ms_min_d     = bus.new_current_time_ms_min;
                ls_min_d     = bus.new_current_time_ls_min;
                load_error_d = 1'b0;
            end else begin
                load_error_d = 1'b1;
            end
        end else if (bus.one_minute) begin
            if (ls_min_q == 4'd9) begin
                ls_min_d = 4'd0;
                if (ms_min_q == 4'd5) begin
                    ms_min_d = 4'd0;
                    if (at_last_hour_s) begin
                        ms_hr_d    = 4'd0;
                        ls_hr_d    = 4'd0;
                        day_tick_d = 1'b1;
                    end else if (ls_hr_q == 4'd9) begin
                        ls_hr_d = 4'd0;
                        ms_hr_d = ms_hr_q + 4'd1;
                    end else begin
                        ls_hr_d = ls_hr_q + 4'd1;
                    end
                end else begin
                    ms_min_d = ms_min_q + 4'd1;
                end
            end else begin
                ls_min_d = ls_min_q + 4'd1;
            end
        end else begin
            day_tick_d = 1'b0;
        end
    end

    // State register: time digits and status flags, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_hr_q      <= 4'd0;
            ls_hr_q      <= 4'd0;
            ms_min_q     <= 4'd0;
            ls_min_q     <= 4'd0;
            day_tick_q   <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            ms_hr_q      <= ms_hr_d;
            ls_hr_q      <= ls_hr_d;
            ms_min_q     <= ms_min_d;
            ls_min_q     <= ls_min_d;
            day_tick_q   <= day_tick_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.current_time_ms_hr  = ms_hr_q;
    assign bus.current_time_ls_hr  = ls_hr_q;
    assign bus.current_time_ms_min = ms_min_q;
    assign bus.current_time_ls_min = ls_min_q;
    assign bus.day_tick            = day_tick_q;
    assign bus.load_error          = load_error_q;

endmodule

`default_nettype wire

// File: tb/tb_aclk_time_counter.sv
// Bench for aclk_time_counter: a 24-hour and a 12-hour instance see the same
// stimulus; a minutes-of-day model per instance is compared every cycle,
// and hand-computed literals pin the key points.
`timescale 1ns/1ps

module tb_aclk_time_counter;

    typedef struct packed {
        logic [10:0] mins;
        logic        err;
        logic        tick;
    } mstate_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    bit   chk_en;
    mstate_t m24, m12;

    aclk_time_counter_if if24();
    aclk_time_counter_if if12();

    aclk_time_counter #(.HOURS_PER_DAY(24)) dut24 (.clk(clk), .reset(reset), .bus(if24));
    aclk_time_counter #(.HOURS_PER_DAY(12)) dut12 (.clk(clk), .reset(reset), .bus(if12));

    logic [15:0] dig24, dig12;
    assign dig24 = {if24.current_time_ms_hr, if24.current_time_ls_hr,
                    if24.current_time_ms_min, if24.current_time_ls_min};
    assign dig12 = {if12.current_time_ms_hr, if12.current_time_ls_hr,
                    if12.current_time_ms_min, if12.current_time_ls_min};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minutes-of-day model for one cycle of input.
    function automatic mstate_t mstep(mstate_t s, int hpd, logic ld, logic tk,
                                      logic [3:0] a, logic [3:0] b,
                                      logic [3:0] c, logic [3:0] d);
        mstate_t n;
        int h;
        int nm;
        n = s;
        n.tick = 1'b0;
        h = int'(a) * 10 + int'(b);
        if (ld) begin
            if (int'(d) <= 9 && int'(c) <= 5 && int'(b) <= 9 && h < hpd) begin
                n.mins = 11'(h * 60 + int'(c) * 10 + int'(d));
                n.err  = 1'b0;
            end else begin
                n.err = 1'b1;
            end
        end else if (tk) begin
            nm = (int'(s.mins) + 1) % (hpd * 60);
            n.mins = 11'(nm);
            n.tick = (nm == 0);
        end
        return n;
    endfunction

    function automatic logic [15:0] to_digits(logic [10:0] mins);
        int h;
        int m;
        h = int'(mins) / 60;
        m = int'(mins) % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Models advance on the same edge as the DUTs and clear with the reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m24 <= '0;
            m12 <= '0;
        end else begin
            m24 <= mstep(m24, 24, if24.load_new_c, if24.one_minute,
                         if24.new_current_time_ms_hr, if24.new_current_time_ls_hr,
                         if24.new_current_time_ms_min, if24.new_current_time_ls_min);
            m12 <= mstep(m12, 12, if12.load_new_c, if12.one_minute,
                         if12.new_current_time_ms_hr, if12.new_current_time_ls_hr,
                         if12.new_current_time_ms_min, if12.new_current_time_ls_min);
        end
    end

    // Every-cycle comparison against the models, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("time24", 32'(dig24), 32'(to_digits(m24.mins)));
            chk("tick24", 32'(if24.day_tick), 32'(m24.tick));
            chk("err24", 32'(if24.load_error), 32'(m24.err));
            chk("time12", 32'(dig12), 32'(to_digits(m12.mins)));
            chk("tick12", 32'(if12.day_tick), 32'(m12.tick));
            chk("err12", 32'(if12.load_error), 32'(m12.err));
        end
    end

    // Apply one cycle of stimulus to both instances, return 1ns after the edge.
    task automatic step(input logic ld, input logic tk, input logic [15:0] t);
        if24.load_new_c = ld;
        if24.one_minute = tk;
        {if24.new_current_time_ms_hr, if24.new_current_time_ls_hr,
         if24.new_current_time_ms_min, if24.new_current_time_ls_min} = t;
        if12.load_new_c = ld;
        if12.one_minute = tk;
        {if12.new_current_time_ms_hr, if12.new_current_time_ls_hr,
         if12.new_current_time_ms_min, if12.new_current_time_ls_min} = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        reset  = 1'b1;
        if24.load_new_c = 1'b0;
        if24.one_minute = 1'b0;
        if12.load_new_c = 1'b0;
        if12.one_minute = 1'b0;
        {if24.new_current_time_ms_hr, if24.new_current_time_ls_hr,
         if24.new_current_time_ms_min, if24.new_current_time_ls_min} = 16'h0000;
        {if12.new_current_time_ms_hr, if12.new_current_time_ls_hr,
         if12.new_current_time_ms_min, if12.new_current_time_ls_min} = 16'h0000;
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;

        // Ticks while reset is held are ignored.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'h0000);
            chk("rst_time", 32'(dig24), 32'h0000);
            chk("rst_tick", 32'(if24.day_tick), 32'h0);
            chk("rst_err", 32'(if24.load_error), 32'h0);
        end
        reset = 1'b1;

        // 12:58 -> 12:59 -> 13:00
        step(1'b1, 1'b0, 16'h1258);
        chk("load_1258", 32'(dig24), 32'h1258);
        step(1'b0, 1'b1, 16'h0000);
        chk("tick_1259", 32'(dig24), 32'h1259);
        step(1'b0, 1'b1, 16'h0000);
        chk("tick_1300", 32'(dig24), 32'h1300);

        // 23:59 -> 00:00 with day_tick, then 00:01 without
        step(1'b1, 1'b0, 16'h2359);
        chk("err12_2359", 32'(if12.load_error), 32'h1);
        step(1'b0, 1'b1, 16'h0000);
        chk("wrap_0000", 32'(dig24), 32'h0000);
        chk("wrap_tick", 32'(if24.day_tick), 32'h1);
        step(1'b0, 1'b1, 16'h0000);
        chk("after_0001", 32'(dig24), 32'h0001);
        chk("after_tick", 32'(if24.day_tick), 32'h0);

        // Illegal loads keep the time and set the sticky error
        step(1'b1, 1'b0, 16'h2400);
        chk("bad2400_t", 32'(dig24), 32'h0001);
        chk("bad2400_e", 32'(if24.load_error), 32'h1);
        step(1'b0, 1'b0, 16'h0000);
        chk("sticky_err", 32'(if24.load_error), 32'h1);
        step(1'b1, 1'b0, 16'h0760);
        chk("bad0760_t", 32'(dig24), 32'h0001);
        chk("bad0760_e", 32'(if24.load_error), 32'h1);
        step(1'b1, 1'b0, 16'h0730);
        chk("ok0730_t", 32'(dig24), 32'h0730);
        chk("ok0730_e", 32'(if24.load_error), 32'h0);

        // Load beats tick; the tick is discarded
        step(1'b1, 1'b1, 16'h0909);
        chk("ldtick_0909", 32'(dig24), 32'h0909);
        step(1'b0, 1'b1, 16'h0000);
        chk("next_0910", 32'(dig24), 32'h0910);
        step(1'b1, 1'b1, 16'h2500);
        chk("badld_tick_t", 32'(dig24), 32'h0910);
        chk("badld_tick_e", 32'(if24.load_error), 32'h1);

        // 12-hour wrap and 12:00 rejection
        step(1'b1, 1'b0, 16'h1159);
        step(1'b0, 1'b1, 16'h0000);
        chk("w12_time", 32'(dig12), 32'h0000);
        chk("w12_tick", 32'(if12.day_tick), 32'h1);
        chk("w24_1200", 32'(dig24), 32'h1200);
        step(1'b0, 1'b0, 16'h0000);
        chk("w12_tick_off", 32'(if12.day_tick), 32'h0);
        step(1'b1, 1'b0, 16'h1200);
        chk("r12_err", 32'(if12.load_error), 32'h1);
        chk("r12_time", 32'(dig12), 32'h0000);

        // Load of 00:00 never pulses day_tick
        step(1'b1, 1'b0, 16'h0000);
        chk("ld0000_tick", 32'(if24.day_tick), 32'h0);

        // Continuous tick stream across midnight and hour boundaries
        step(1'b1, 1'b0, 16'h2357);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0000);
        chk("stream_0002", 32'(dig24), 32'h0002);
        step(1'b1, 1'b0, 16'h0958);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000);
        chk("stream_1001", 32'(dig24), 32'h1001);

        // Asynchronous reset mid-cycle
        step(1'b1, 1'b0, 16'h1545);
        chk("pre_rst_1545", 32'(dig24), 32'h1545);
        step(1'b0, 1'b0, 16'h0000);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_t", 32'(dig24), 32'h0000);
        chk("async_rst_12", 32'(dig12), 32'h0000);
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b0, 1'b1, 16'h0000);
        chk("post_rst_0001", 32'(dig24), 32'h0001);
        step(1'b0, 1'b0, 16'h0000);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
